// File: rtl/jacobian_to_affine_if.sv
// Request/result bundle for the Jacobian-to-affine converter.
// The master side issues start with X/Y/Z. The slave side returns the affine point and status.
interface jacobian_to_affine_if;
    logic         start;
    logic [255:0] X;
    logic [255:0] Y;
    logic [255:0] Z;
    logic [255:0] x_out;
    logic [255:0] y_out;
    logic         infinity;
    logic         busy;
    logic         done;

    modport master (
        output start, X, Y, Z,
        input  x_out, y_out, infinity, busy, done
    );

    modport slave (
        input  start, X, Y, Z,
        output x_out, y_out, infinity, busy, done
    );
endinterface

// File: rtl/jacobian_to_affine.sv
// Converts a secp256k1 Jacobian point to affine form using Fermat inversion Z^(P-2).
// A single shared modular multiplier, with one cycle of latency, serves every step.
module jacobian_to_affine (
    input logic                  clk,
    input logic                  rst,
    jacobian_to_affine_if.slave  bus
);
    localparam logic [255:0] P     =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] EXP   = P - 256'd2;
    // 2^256 mod P, used to fold the high half of a product back into range.
    localparam logic [33:0]  RED_C = 34'h1_0000_03D1;

    typedef enum logic [2:0] {
        StIdle, StInvSq, StInvMul, StZi2, StXa, StZi3, StYa, StDone
    } state_e;

    state_e       state_q, state_d;
    logic         pend_q, pend_d;
    logic [7:0]   idx_q, idx_d;
    logic [255:0] acc_q, acc_d;
    logic [255:0] t_q, t_d;
    logic [255:0] x_reg_q, x_reg_d;
    logic [255:0] y_reg_q, y_reg_d;
    logic [255:0] z_reg_q, z_reg_d;
    logic [255:0] x_out_q, x_out_d;
    logic [255:0] y_out_q, y_out_d;
    logic         inf_q, inf_d;

    logic         start_mul;
    logic [255:0] mul_a, mul_b;
    logic         mul_done_q, mul_done_d;
    logic [255:0] mul_res_q, mul_res_d;
    logic [511:0] prod;
    logic [289:0] fold1;
    logic [256:0] fold2;
    logic [255:0] fold3, mul_red;

    // Multiplier: full product, two folds of the high part, then one conditional subtract.
    always_comb begin
        prod       = {256'd0, mul_a} * {256'd0, mul_b};
        fold1      = 290'(prod[255:0]) + 290'(prod[511:256]) * 290'(RED_C);
        fold2      = 257'(fold1[255:0]) + 257'(fold1[289:256]) * 257'(RED_C);
        fold3      = fold2[255:0] + (fold2[256] ? 256'(RED_C) : 256'd0);
        mul_red    = (fold3 >= P) ? fold3 - P : fold3;
        mul_done_d = start_mul;
        mul_res_d  = start_mul ? mul_red : mul_res_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_done_q <= 1'b0;
            mul_res_q  <= '0;
        end else begin
            mul_done_q <= mul_done_d;
            mul_res_q  <= mul_res_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pend_q  <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            t_q     <= '0;
            x_reg_q <= '0;
            y_reg_q <= '0;
            z_reg_q <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            inf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            t_q     <= t_d;
            x_reg_q <= x_reg_d;
            y_reg_q <= y_reg_d;
            z_reg_q <= z_reg_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            inf_q   <= inf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        t_d       = t_q;
        x_reg_d   = x_reg_q;
        y_reg_d   = y_reg_q;
        z_reg_d   = z_reg_q;
        x_out_d   = x_out_q;
        y_out_d   = y_out_q;
        inf_d     = inf_q;
        start_mul = 1'b0;
        mul_a     = acc_q;
        mul_b     = acc_q;

        unique case (state_q)
            StInvMul: mul_b = z_reg_q;
            StXa: begin
                mul_a = x_reg_q;
                mul_b = t_q;
            end
            StZi3:    mul_a = t_q;
            StYa: begin
                mul_a = y_reg_q;
                mul_b = t_q;
            end
            default: ;
        endcase

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    x_reg_d = bus.X;
                    y_reg_d = bus.Y;
                    z_reg_d = bus.Z;
                    inf_d   = 1'b0;
                    if (bus.Z == '0) begin
                        inf_d   = 1'b1;
                        x_out_d = '0;
                        y_out_d = '0;
                        state_d = StDone;
                    end else begin
                        acc_d   = bus.Z;
                        idx_d   = 8'd254;
                        state_d = StInvSq;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: begin
                // Each step: issue cycle, then consume the result once mul_done follows.
                if (!pend_q) begin
                    start_mul = 1'b1;
                    pend_d    = 1'b1;
                end else if (mul_done_q) begin
                    pend_d = 1'b0;
                    unique case (state_q)
                        StInvSq: begin
                            acc_d = mul_res_q;
                            if (EXP[idx_q]) begin
                                state_d = StInvMul;
                            end else if (idx_q == 8'd0) begin
                                state_d = StZi2;
                            end else begin
                                idx_d = idx_q - 8'd1;
                            end
                        end
                        StInvMul: begin
                            acc_d = mul_res_q;
                            if (idx_q == 8'd0) begin
                                state_d = StZi2;
                            end else begin
                                idx_d   = idx_q - 8'd1;
                                state_d = StInvSq;
                            end
                        end
                        StZi2: begin
                            t_d     = mul_res_q;
                            state_d = StXa;
                        end
                        StXa: begin
                            x_out_d = mul_res_q;
                            state_d = StZi3;
                        end
                        StZi3: begin
                            t_d     = mul_res_q;
                            state_d = StYa;
                        end
                        StYa: begin
                            y_out_d = mul_res_q;
                            state_d = StDone;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    assign bus.x_out    = x_out_q;
    assign bus.y_out    = y_out_q;
    assign bus.infinity = inf_q;
    assign bus.done     = (state_q == StDone);
    assign bus.busy     = (state_q != StIdle) && (state_q != StDone);
endmodule

// File: tb/tb_jacobian_to_affine.sv
// Directed and random checks of jacobian_to_affine against a plain modular-arithmetic model.
module tb_jacobian_to_affine;
    localparam logic [255:0] P   =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] GX  =
        256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
    localparam logic [255:0] GY  =
        256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
    localparam logic [255:0] G2X =
        256'hC6047F94_41ED7D6D_3045406E_95C07CD8_5C778E4B_8CEF3CA7_ABAC09B9_5C709EE5;
    localparam logic [255:0] G2Y =
        256'h1AE168FE_A63DC339_A3C58419_466CEAEE_F7F63265_3266D0E1_236431A9_50CFE52A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jacobian_to_affine_if bus ();
    jacobian_to_affine dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int mul_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (dut.start_mul) mul_cnt <= mul_cnt + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [255:0] mulm(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] t;
        t = ({256'd0, a} * {256'd0, b}) % {256'd0, P};
        return t[255:0];
    endfunction

    function automatic logic [255:0] addm(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[255:0];
    endfunction

    function automatic logic [255:0] subm(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = (a >= b) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, P} - {1'b0, b};
        return s[255:0];
    endfunction

    function automatic logic [255:0] powm(input logic [255:0] b, input logic [255:0] e);
        logic [255:0] r;
        logic [255:0] base;
        r = 256'd1;
        base = b;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = mulm(r, base);
            base = mulm(base, base);
        end
        return r;
    endfunction

    task automatic ref_affine(input logic [255:0] x, input logic [255:0] y,
                              input logic [255:0] z,
                              output logic [255:0] ex, output logic [255:0] ey);
        logic [255:0] zi, zi2;
        zi  = powm(z, P - 256'd2);
        zi2 = mulm(zi, zi);
        ex  = mulm(x, zi2);
        ey  = mulm(y, mulm(zi2, zi));
    endtask

    task automatic jdouble(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z,
                           output logic [255:0] x3, output logic [255:0] y3,
                           output logic [255:0] z3);
        logic [255:0] yy, s, m;
        yy = mulm(y, y);
        s  = mulm(256'd4, mulm(x, yy));
        m  = mulm(256'd3, mulm(x, x));
        x3 = subm(mulm(m, m), addm(s, s));
        y3 = subm(mulm(m, subm(s, x3)), mulm(256'd8, mulm(yy, yy)));
        z3 = mulm(256'd2, mulm(y, z));
    endtask

    function automatic logic [255:0] rnd_fe();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        if (v >= P) v = v - P;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.X = x;
        bus.Y = y;
        bus.Z = z;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.X = rnd_fe();
        bus.Y = rnd_fe();
        bus.Z = rnd_fe();
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.done && cyc < 3000);
        checks++;
        assert (bus.done === 1'b1) else begin
            errors++;
            $error("FAIL %s_timeout observed done=%b after %0d cycles expected done=1", tag,
                   bus.done, cyc);
        end
    endtask

    task automatic run_job(input string tag, input logic [255:0] x, input logic [255:0] y,
                           input logic [255:0] z, output logic [255:0] rx,
                           output logic [255:0] ry, output logic rinf, output logic rbusy,
                           output int pulses, output int dones, output int cyc);
        int m0, d0;
        m0 = mul_cnt;
        d0 = done_cnt;
        launch(x, y, z);
        rbusy = bus.busy;
        wait_done(tag, cyc);
        rx   = bus.x_out;
        ry   = bus.y_out;
        rinf = bus.infinity;
        repeat (4) @(negedge clk);
        pulses = mul_cnt - m0;
        dones  = done_cnt - d0;
    endtask

    initial begin
        logic [255:0] rx, ry, ex, ey, x2, y2, z2, ax, ay, az;
        logic rinf, rbusy;
        int pulses, dones, cyc, m0, d0, exp_ops;

        bus.start = 1'b0;
        bus.X = '0;
        bus.Y = '0;
        bus.Z = '0;
        // Op count from the algorithm: 255 squarings, one multiply per set bit below the MSB, 4 tail.
        exp_ops = 255 + ($countones(P - 256'd2) - 1) + 4;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_x", bus.x_out, 256'd0);
        chk("rst_y", bus.y_out, 256'd0);
        chk("rst_inf", 256'(bus.infinity), 256'd0);
        chk("rst_busy", 256'(bus.busy), 256'd0);
        chk("rst_done", 256'(bus.done), 256'd0);

        run_job("g_z1", GX, GY, 256'd1, rx, ry, rinf, rbusy, pulses, dones, cyc);
        chk("g_z1_x", rx, GX);
        chk("g_z1_y", ry, GY);
        chk("g_z1_inf", 256'(rinf), 256'd0);
        chk("g_z1_busy", 256'(rbusy), 256'd1);
        chk("g_z1_ops", 256'(pulses), 256'(exp_ops));
        chk("g_z1_dones", 256'(dones), 256'd1);

        run_job("g_z2", mulm(256'd4, GX), mulm(256'd8, GY), 256'd2, rx, ry, rinf, rbusy,
                pulses, dones, cyc);
        chk("g_z2_x", rx, GX);
        chk("g_z2_y", ry, GY);

        run_job("z0", rnd_fe(), rnd_fe(), 256'd0, rx, ry, rinf, rbusy, pulses, dones, cyc);
        chk("z0_latency", 256'(cyc), 256'd1);
        chk("z0_inf", 256'(rinf), 256'd1);
        chk("z0_x", rx, 256'd0);
        chk("z0_y", ry, 256'd0);
        chk("z0_busy", 256'(rbusy), 256'd0);
        chk("z0_ops", 256'(pulses), 256'd0);
        chk("z0_dones", 256'(dones), 256'd1);

        jdouble(GX, GY, 256'd1, x2, y2, z2);
        run_job("dbl", x2, y2, z2, rx, ry, rinf, rbusy, pulses, dones, cyc);
        chk("dbl_x", rx, G2X);
        chk("dbl_y", ry, G2Y);
        chk("dbl_inf", 256'(rinf), 256'd0);

        for (int k = 0; k < 3; k++) begin
            ax = rnd_fe();
            ay = rnd_fe();
            do az = rnd_fe(); while (az == '0);
            ref_affine(ax, ay, az, ex, ey);
            run_job("rnd", ax, ay, az, rx, ry, rinf, rbusy, pulses, dones, cyc);
            chk("rnd_x", rx, ex);
            chk("rnd_y", ry, ey);
            chk("rnd_ops", 256'(pulses), 256'(exp_ops));
        end

        // Abort a job with reset after roughly 100 multiplies.
        m0 = mul_cnt;
        launch(GX, GY, 256'd1);
        cyc = 0;
        while (mul_cnt - m0 < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reach", 256'(mul_cnt - m0 >= 100), 256'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        d0 = done_cnt;
        m0 = mul_cnt;
        chk("abort_x", bus.x_out, 256'd0);
        chk("abort_y", bus.y_out, 256'd0);
        chk("abort_inf", 256'(bus.infinity), 256'd0);
        chk("abort_busy", 256'(bus.busy), 256'd0);
        chk("abort_done", 256'(bus.done), 256'd0);
        repeat (1100) @(negedge clk);
        chk("abort_no_done", 256'(done_cnt - d0), 256'd0);
        chk("abort_no_ops", 256'(mul_cnt - m0), 256'd0);
        run_job("after_abort", GX, GY, 256'd1, rx, ry, rinf, rbusy, pulses, dones, cyc);
        chk("after_abort_x", rx, GX);
        chk("after_abort_y", ry, GY);

        // Second start mid-job must be ignored.
        ax = rnd_fe();
        ay = rnd_fe();
        do az = rnd_fe(); while (az == '0);
        ref_affine(ax, ay, az, ex, ey);
        m0 = mul_cnt;
        d0 = done_cnt;
        launch(ax, ay, az);
        repeat (200) @(negedge clk);
        launch(GX, GY, 256'd1);
        wait_done("midstart", cyc);
        rx = bus.x_out;
        ry = bus.y_out;
        repeat (40) @(negedge clk);
        chk("midstart_x", rx, ex);
        chk("midstart_y", ry, ey);
        chk("midstart_dones", 256'(done_cnt - d0), 256'd1);
        chk("midstart_ops", 256'(mul_cnt - m0), 256'(exp_ops));
        chk("hold_x", bus.x_out, ex);
        chk("hold_y", bus.y_out, ey);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
